nibble_serial_addsub: RTL
=========================

# nibble_serial_addsub

Multi-cycle add/subtract unit that computes WIDTH-bit results by pushing operands 4 bits per cycle through a single 4-bit carry-lookahead slice. The carry is registered between slices. It sits between the operand-issue logic and the result-writeback stage, trading latency for area on wide operands. Both sides use valid/ready handshakes.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and ≥ 8
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand set valid
- in_ready  out  1  unit can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- sub  in  1  0 = A+B+cin, 1 = A−B (A + ~B + 1; cin ignored)
- cin  in  1  carry in for ADD
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out of MSB (SUB: 1 = no borrow)
- ovf  out  1  signed overflow = carry into MSB XOR cout

## Operation
- N = WIDTH/4 nibble steps per operation.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch a, b (pre-inverted if sub), carry = sub ? 1 : cin, clear step counter k=0, go to RUN.
  - RUN: each cycle feed nibble k of the latched A and B plus the carry register into the slice. Write the slice sum into sum[4k+3:4k], update the carry register with the slice carry out, k++. After step k=N−1, register cout and ovf, go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Port values on a/b/sub/cin outside the IDLE acceptance cycle are ignored; the latched copies are used.
- The step counter is $clog2(N) bits wide and never wraps past N−1. The RUN→DONE exit is decoded from k==N−1.
- Arithmetic is unsigned modulo 2^WIDTH. ovf uses the slice's internal carry into bit 3 on the final step.
- Reset (asserted at any time, including mid-RUN or in DONE with out_ready low) forces IDLE immediately and discards any partial result. No result is emitted for the aborted operation.

## Timing
- Reset values: in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, carry register=0, k=0.
- Acceptance edge T0 (in_valid & in_ready). Nibble steps occur on edges T1..TN. out_valid is high from TN until the edge where out_ready is sampled high.
- Latency: N cycles from acceptance to out_valid, i.e. 4 cycles at WIDTH=16.
- Throughput: one operation per N+2 cycles with out_ready held high (accept, N steps, DONE, IDLE).
- in_ready is low throughout RUN and DONE. There is no overlap between consecutive operations.
- While out_valid=1 and out_ready=0, sum, cout and ovf are held stable.
- in_ready, out_valid, sum, cout and ovf are all driven from registers or state decode. There are no combinational paths from in_valid or out_ready to any output.

## Structure
- Shared package nibble_arith_pkg:
  - state enum {IDLE, RUN, DONE}
  - localparam NIBBLE_W = 4
- Sub-module cla_nibble:
  - Combinational 4-bit carry-lookahead slice: P=A^B, G=A&B, ripple-free carry equations.
  - Outputs: sum[3:0], cout, c3 (carry into bit 3, used for ovf).
- The top level holds the FSM, operand registers, step counter, carry register and result register.

## Test plan
- ADD, WIDTH=16: a=0x1234, b=0x0FFF, cin=0 → sum=0x2233, cout=0, ovf=0; out_valid exactly 4 cycles after acceptance.
- ADD wrap: a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. Carry must propagate through all 4 nibble steps.
- SUB: a=0x0005, b=0x0007, sub=1, cin=1 (ignored) → sum=0xFFFE, cout=0 (borrow), ovf=0.
- Signed overflow: a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, cout=0, ovf=1.
- Backpressure: after a result, hold out_ready=0 for 5 cycles → sum/cout/ovf stable, out_valid=1, in_ready=0, new in_valid ignored. Raise out_ready → in_ready=1 the following cycle.
- Reset mid-RUN: assert rst_n=0 during step 2 → all outputs return to reset values asynchronously, and no out_valid appears after release. The next operation, a=0x0001, b=0x0001, returns sum=0x0002.

Source files
------------

// File: rtl/nibble_arith_pkg.sv
// Shared types and constants for the nibble-serial add/subtract unit.
package nibble_arith_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cla_nibble.sv
// Combinational 4-bit carry-lookahead slice; c3 is exposed for signed-overflow detection.
module cla_nibble
  import nibble_arith_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout,
  output logic                c3
);

  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W:0]   c;

  for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_pg
    assign p[gi] = a[gi] ^ b[gi];
    assign g[gi] = a[gi] & b[gi];
  end

  // Each carry is a flat sum of products of generate/propagate terms, so no carry ripples.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[NIBBLE_W-1:0];
  assign cout = c[4];
  assign c3   = c[3];

endmodule

// File: rtl/nibble_serial_addsub.sv
// WIDTH-bit add/subtract computed one nibble per cycle through a single CLA slice,
// with valid/ready handshakes on both the operand and the result side.
module nibble_serial_addsub
  import nibble_arith_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / NIBBLE_W;
  localparam int KW = $clog2(N);

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [KW-1:0]    k_q, k_d;

  logic [NIBBLE_W-1:0] a_nib [N];
  logic [NIBBLE_W-1:0] b_nib [N];
  logic [NIBBLE_W-1:0] slice_sum;
  logic                slice_cout;
  logic                slice_c3;
  logic                last_step;

  for (genvar gi = 0; gi < N; gi++) begin : g_nib
    assign a_nib[gi] = a_q[gi*NIBBLE_W +: NIBBLE_W];
    assign b_nib[gi] = b_q[gi*NIBBLE_W +: NIBBLE_W];
  end

  assign last_step = (k_q == KW'(N - 1));

  cla_nibble u_cla (
    .a    (a_nib[k_q]),
    .b    (b_nib[k_q]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout),
    .c3   (slice_c3)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    sum       = sum_q;
    cout      = cout_q;
    ovf       = ovf_q;
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction is A + ~B + 1, so B is inverted once here and the carry seeded with 1.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          k_d     = '0;
        end
      end
      RUN: begin
        for (int i = 0; i < N; i++) begin
          if (k_q == KW'(i)) sum_d[i*NIBBLE_W +: NIBBLE_W] = slice_sum;
        end
        carry_d = slice_cout;
        if (last_step) begin
          cout_d = slice_cout;
          ovf_d  = slice_c3 ^ slice_cout;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      k_q     <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      k_q     <= k_d;
    end
  end

endmodule
